// File: rtl/alu16_issue.sv
// alu16_issue: command issue stage in front of the bit-serial alu16.
// Takes {a,b,op} commands over valid/ready and drives the alu16 operands and its 'on' pulse.
// It times the serial computation, captures the 17-bit result and offers it on a valid/ready
// result port.
// Optional feature: define ALU_ISSUE_SKID_EN to add a one-entry command skid buffer, so one
// command can be accepted while a previous one is still in flight.
module alu16_issue #(
  parameter int ON_CYCLES   = 2,
  parameter int ALU_LATENCY = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [16:0] res_data,
  output logic        busy,
  output logic [15:0] alu_ina,
  output logic [15:0] alu_inb,
  output logic [2:0]  alu_op,
  output logic        alu_on,
  input  logic [16:0] alu_out
);

  localparam int MAX_CNT = (ON_CYCLES > ALU_LATENCY) ? ON_CYCLES : ALU_LATENCY;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] ON_RELOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] RUN_RELOAD = CW'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          cmd_fire;
  logic          res_fire;
  logic          done_fire;
  logic          take_cmd;
  logic          take_skid;

  assign cnt_zero  = (cnt == '0);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign res_fire  = res_valid & res_ready;
  assign done_fire = (state == DONE) & res_fire;
  assign busy      = (state != IDLE);
  assign alu_on    = (state == LOAD);

`ifdef ALU_ISSUE_SKID_EN
  logic        skid_full;
  logic [15:0] skid_a;
  logic [15:0] skid_b;
  logic [2:0]  skid_op;

  assign cmd_ready = ~skid_full;
  assign take_skid = done_fire & skid_full;
  // A command goes straight to the ALU when idle, or when the result drains with an empty skid.
  assign take_cmd  = cmd_fire & ((state == IDLE) | (done_fire & ~skid_full));

  // Skid buffer holds one command accepted while the ALU is busy; draining it frees the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_a    <= '0;
      skid_b    <= '0;
      skid_op   <= '0;
    end else begin
      if (cmd_fire && !take_cmd) begin
        skid_full <= 1'b1;
        skid_a    <= cmd_a;
        skid_b    <= cmd_b;
        skid_op   <= cmd_op;
      end else if (take_skid) begin
        skid_full <= 1'b0;
      end
    end
  end
`else
  assign cmd_ready = (state == IDLE);
  assign take_skid = 1'b0;
  assign take_cmd  = cmd_fire;
`endif

  // State register for the IDLE -> LOAD -> RUN -> DONE sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: timed phases advance when the shared counter expires.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (take_cmd) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (cnt_zero) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt_zero) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (done_fire) begin
          next_state = (take_cmd || take_skid) ? LOAD : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Single down-counter, reloaded whenever LOAD or RUN is entered, otherwise counts to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((next_state == LOAD) && (state != LOAD)) begin
      cnt <= ON_RELOAD;
    end else if ((next_state == RUN) && (state != RUN)) begin
      cnt <= RUN_RELOAD;
    end else if (!cnt_zero) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Operand latch on issue and result capture on the closing edge of RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ina   <= '0;
      alu_inb   <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (take_cmd) begin
        alu_ina <= cmd_a;
        alu_inb <= cmd_b;
        alu_op  <= cmd_op;
      end
`ifdef ALU_ISSUE_SKID_EN
      else if (take_skid) begin
        alu_ina <= skid_a;
        alu_inb <= skid_b;
        alu_op  <= skid_op;
      end
`endif
      if ((state == RUN) && cnt_zero) begin
        res_data  <= alu_out;
        res_valid <= 1'b1;
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu16_issue.sv
// tb_alu16_issue: self-checking bench for alu16_issue.
// A behavioural alu16 stand-in presents the correct result only in the single cycle in which
// it becomes valid, and junk otherwise.
// Expected results come from a plain-arithmetic reference of the opcode table. That reference
// is applied to the commands the bench itself issued.
// Define ALU_ISSUE_SKID_EN to also exercise the skid-buffer build.
`timescale 1ns/1ps
module tb_alu16_issue;

  localparam int ON_CYCLES   = 2;
  localparam int ALU_LATENCY = 17;
  localparam int RES_CYCLE   = ON_CYCLES + ALU_LATENCY + 1;
`ifdef ALU_ISSUE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_data;
  logic        busy;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic [2:0]  alu_op;
  logic        alu_on;
  logic [16:0] alu_out;

  int checks = 0;
  int errors = 0;

  alu16_issue #(
    .ON_CYCLES  (ON_CYCLES),
    .ALU_LATENCY(ALU_LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_op   (cmd_op),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy),
    .alu_ina  (alu_ina),
    .alu_inb  (alu_inb),
    .alu_op   (alu_op),
    .alu_on   (alu_on),
    .alu_out  (alu_out)
  );

  always #5 clk = ~clk;

  // Reference alu16 behaviour: 17-bit result, bit 16 is carry/extension.
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {1'b0, b};
    endcase
  endfunction

  // alu16 stand-in: counts cycles since 'on' dropped; output is valid only on cycle ALU_LATENCY.
  int          run_cnt = 1000;
  logic [16:0] junk = 17'h1;

  always @(posedge clk) begin
    junk <= 17'($urandom) | 17'h1;
    if (alu_on) begin
      run_cnt <= 1;
    end else if (run_cnt < 1000) begin
      run_cnt <= run_cnt + 1;
    end
  end

  assign alu_out = (run_cnt == ALU_LATENCY) ? ref_alu(alu_ina, alu_inb, alu_op)
                                            : (ref_alu(alu_ina, alu_inb, alu_op) ^ junk);

  // Offer a command at a negedge and return at the negedge of cycle 1 after acceptance.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL issue_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_a     = 16'hDEAD;
    cmd_b     = 16'hBEEF;
    cmd_op    = 3'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (alu_on !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: on=%b rv=%b busy=%b rdy=%b, required 0 0 0 1",
               alu_on, res_valid, busy, cmd_ready);
    end
    checks++;
    if (alu_ina !== 16'h0 || alu_inb !== 16'h0 || alu_op !== 3'd0 || res_data !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: ina=%h inb=%h op=%h res=%h, required all zero",
               alu_ina, alu_inb, alu_op, res_data);
    end
    cmd_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic e_on;
    logic e_rv;
    res_ready = 1'b1;
    issue(16'h7002, 16'h8003, 3'd0);
    for (int k = 1; k <= RES_CYCLE; k++) begin
      e_on = (k <= ON_CYCLES);
      e_rv = (k == RES_CYCLE);
      checks++;
      if (alu_on !== e_on || res_valid !== e_rv || busy !== 1'b1 || cmd_ready !== SKID) begin
        errors++;
        $display("[TB] FAIL latency_c%0d: on=%b rv=%b busy=%b rdy=%b, required %b %b 1 %b",
                 k, alu_on, res_valid, busy, cmd_ready, e_on, e_rv, SKID);
      end
      if (k < RES_CYCLE) @(negedge clk);
    end
    checks++;
    if (res_data !== 17'h0F005) begin
      errors++;
      $display("[TB] FAIL latency_result: got %h, required 0f005", res_data);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_idle: rv=%b busy=%b rdy=%b, required 0 0 1",
               res_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_carry();
    res_ready = 1'b1;
    issue(16'hFFFF, 16'h0001, 3'd0);
    for (int k = 1; k <= RES_CYCLE; k++) begin
      checks++;
      if (alu_ina !== 16'hFFFF || alu_inb !== 16'h0001 || alu_op !== 3'd0) begin
        errors++;
        $display("[TB] FAIL carry_operands_c%0d: ina=%h inb=%h op=%h, required ffff 0001 0",
                 k, alu_ina, alu_inb, alu_op);
      end
      if (k < RES_CYCLE) @(negedge clk);
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 17'h10000) begin
      errors++;
      $display("[TB] FAIL carry_result: rv=%b res=%h, required 1 10000", res_valid, res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    issue(16'h1234, 16'h4321, 3'd0);
    for (int k = 1; k < RES_CYCLE; k++) @(negedge clk);
    for (int h = 0; h < 10; h++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 17'h05555 || busy !== 1'b1 || cmd_ready !== SKID) begin
        errors++;
        $display("[TB] FAIL backpressure_hold%0d: rv=%b res=%h busy=%b rdy=%b, required 1 05555 1 %b",
                 h, res_valid, res_data, busy, cmd_ready, SKID);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || res_data !== 17'h05555) begin
      errors++;
      $display("[TB] FAIL backpressure_release: rv=%b busy=%b rdy=%b res=%h, required 0 0 1 05555",
               res_valid, busy, cmd_ready, res_data);
    end
  endtask

  task automatic test_reset_midop();
    logic e_rv;
    res_ready = 1'b1;
    issue(16'($urandom), 16'($urandom), 3'd0);
    for (int k = 1; k < 8; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_on !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        res_data !== 17'h0) begin
      errors++;
      $display("[TB] FAIL midop_reset: on=%b rv=%b rdy=%b busy=%b res=%h, required 0 0 1 0 0",
               alu_on, res_valid, cmd_ready, busy, res_data);
    end
    rst = 1'b0;
    issue(16'h0001, 16'h0002, 3'd0);
    for (int k = 1; k <= RES_CYCLE; k++) begin
      e_rv = (k == RES_CYCLE);
      checks++;
      if (res_valid !== e_rv) begin
        errors++;
        $display("[TB] FAIL midop_followup_valid_c%0d: rv=%b, required %b", k, res_valid, e_rv);
      end
      if (k < RES_CYCLE) @(negedge clk);
    end
    checks++;
    if (res_data !== 17'h00003) begin
      errors++;
      $display("[TB] FAIL midop_followup_result: got %h, required 00003", res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_cmd();
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    a  = 16'($urandom);
    b  = 16'($urandom);
    op = 3'($urandom);
    res_ready = 1'b1;
    issue(a, b, op);
    for (int k = 1; k <= RES_CYCLE; k++) begin
      cmd_a     = 16'($urandom);
      cmd_b     = 16'($urandom);
      cmd_op    = 3'($urandom);
      cmd_valid = !SKID && (k < RES_CYCLE);
      checks++;
      if (alu_ina !== a || alu_inb !== b || alu_op !== op) begin
        errors++;
        $display("[TB] FAIL ignore_operands_c%0d: ina=%h inb=%h op=%h, required %h %h %h",
                 k, alu_ina, alu_inb, alu_op, a, b, op);
      end
      if (k < RES_CYCLE) @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== ref_alu(a, b, op)) begin
      errors++;
      $display("[TB] FAIL ignore_result: rv=%b res=%h, required 1 %h",
               res_valid, res_data, ref_alu(a, b, op));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [16:0] expv;
    int          n;
    int          hold;
    for (int t = 0; t < 16; t++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      op   = 3'($urandom);
      expv = ref_alu(a, b, op);
      hold = $urandom_range(4, 0);
      res_ready = 1'b0;
      issue(a, b, op);
      n = 1;
      while (res_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != RES_CYCLE || res_data !== expv) begin
        errors++;
        $display("[TB] FAIL random%0d_result: cycle=%0d res=%h, required cycle %0d res %h",
                 t, n, res_data, RES_CYCLE, expv);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== expv) begin
          errors++;
          $display("[TB] FAIL random%0d_hold: rv=%b res=%h, required 1 %h",
                   t, res_valid, res_data, expv);
        end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || res_data !== expv) begin
        errors++;
        $display("[TB] FAIL random%0d_drain: rv=%b res=%h, required 0 %h",
                 t, res_valid, res_data, expv);
      end
    end
  endtask

`ifdef ALU_ISSUE_SKID_EN
  task automatic test_back_to_back();
    logic [15:0] a1;
    logic [15:0] b1;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        e_rv;
    a1 = 16'($urandom);
    b1 = 16'($urandom);
    a2 = 16'($urandom);
    b2 = 16'($urandom);
    res_ready = 1'b1;
    issue(a1, b1, 3'd0);
    cmd_a     = a2;
    cmd_b     = b2;
    cmd_op    = 3'd0;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_skid_ready: rdy=%b, required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_skid_full: rdy=%b, required 0", cmd_ready);
    end
    for (int k = 2; k < RES_CYCLE; k++) @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== ref_alu(a1, b1, 3'd0)) begin
      errors++;
      $display("[TB] FAIL b2b_first: rv=%b res=%h, required 1 %h",
               res_valid, res_data, ref_alu(a1, b1, 3'd0));
    end
    @(negedge clk);
    checks++;
    if (alu_on !== 1'b1 || alu_ina !== a2 || alu_inb !== b2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_second_load: on=%b ina=%h inb=%h busy=%b, required 1 %h %h 1",
               alu_on, alu_ina, alu_inb, busy, a2, b2);
    end
    for (int k = RES_CYCLE + 2; k <= 2 * RES_CYCLE; k++) begin
      @(negedge clk);
      e_rv = (k == 2 * RES_CYCLE);
      checks++;
      if (res_valid !== e_rv) begin
        errors++;
        $display("[TB] FAIL b2b_second_valid_c%0d: rv=%b, required %b", k, res_valid, e_rv);
      end
    end
    checks++;
    if (res_data !== ref_alu(a2, b2, 3'd0)) begin
      errors++;
      $display("[TB] FAIL b2b_second: res=%h, required %h", res_data, ref_alu(a2, b2, 3'd0));
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 16'h0;
    cmd_b     = 16'h0;
    cmd_op    = 3'd0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_carry();
    test_backpressure();
    test_reset_midop();
    test_ignore_cmd();
    test_random();
`ifdef ALU_ISSUE_SKID_EN
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
